// File: rtl/fir_pkg.sv
// Shared constants and types for the symmetric broadcast FIR and its coefficient sequencer.
package fir_pkg;

    localparam int NUM_TAPS    = 86;
    localparam int FILTER_SIZE = 2 * NUM_TAPS;
    localparam int FILL        = FILTER_SIZE + 1;
    localparam int COEFF_W     = 16;

    typedef enum logic {RUN, SWAP} state_t;

    typedef logic signed [COEFF_W-1:0] coeff_t;

    // Accepted samples needed before the filter window holds only real data.
    function automatic int fill_count(input int taps);
        return 2 * taps + 1;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, the active bank drives the bus.
module fir_coeff_bank #(
    parameter int NUM_TAPS = 86,
    parameter int COEFF_W  = 16,
    parameter int AW       = $clog2(NUM_TAPS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [AW-1:0]               addr,
    input  logic signed [COEFF_W-1:0]   data,
    input  logic                        bank_sel,
    output logic [NUM_TAPS*COEFF_W-1:0] coeff_bus
);

    logic signed [COEFF_W-1:0] bank0 [NUM_TAPS];
    logic signed [COEFF_W-1:0] bank1 [NUM_TAPS];
    logic                      we0;
    logic                      we1;

    // bank_sel names the active bank, so writes steer to the other one.
    assign we0 = we & bank_sel;
    assign we1 = we & ~bank_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            if (we0) bank0[addr] <= data;
            if (we1) bank1[addr] <= data;
        end
    end

    always_comb begin
        coeff_bus = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            coeff_bus[i*COEFF_W +: COEFF_W] = bank_sel ? bank1[i] : bank0[i];
        end
    end

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Sequences the symmetric FIR: gates samples into the filter, loads coefficients
// into a shadow bank and commits them with a one-cycle swap that can flush the filter.
module fir_coeff_sequencer #(
    parameter int NUM_TAPS      = fir_pkg::NUM_TAPS,
    parameter int COEFF_W       = fir_pkg::COEFF_W,
    parameter int DATA_W        = 16,
    parameter bit CLEAR_ON_SWAP = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          in_ready,
    input  logic                          cfg_valid,
    input  logic [$clog2(NUM_TAPS)-1:0]   cfg_addr,
    input  logic signed [COEFF_W-1:0]     cfg_data,
    input  logic                          cfg_last,
    output logic                          cfg_ready,
    output logic                          filt_en,
    output logic signed [DATA_W-1:0]      filt_data,
    output logic                          filt_reset,
    output logic [NUM_TAPS*COEFF_W-1:0]   coeff_bus,
    output logic                          out_valid,
    output logic                          active_bank,
    output logic                          cfg_err
);
    import fir_pkg::*;

    localparam int AW     = $clog2(NUM_TAPS);
    localparam int FILL_N = fill_count(NUM_TAPS);
    localparam int CNT_W  = $clog2(FILL_N + 1);

    state_t           state;
    state_t           state_next;
    logic             swap_pending;
    logic             cfg_fire;
    logic             addr_ok;
    logic             fill_clear;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] fill_inc;
    logic [CNT_W-1:0] fill_next;

    function automatic logic [CNT_W-1:0] fill_sat_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_W'(FILL_N)) return CNT_W'(FILL_N);
        return c + CNT_W'(1);
    endfunction

    assign cfg_ready = ~swap_pending & (state == RUN) & ~reset;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign addr_ok   = (32'(cfg_addr) < NUM_TAPS);
    assign filt_en   = in_valid & in_ready;
    assign filt_data = in_data;

    fir_coeff_bank #(
        .NUM_TAPS (NUM_TAPS),
        .COEFF_W  (COEFF_W),
        .AW       (AW)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .we        (cfg_fire & addr_ok),
        .addr      (cfg_addr),
        .data      (cfg_data),
        .bank_sel  (active_bank),
        .coeff_bus (coeff_bus)
    );

    // The swap starts the cycle after cfg_last is accepted, so the request is
    // taken straight from the handshake as well as from the pending flag.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        filt_reset = reset;
        fill_clear = 1'b0;
        unique case (state)
            RUN: begin
                in_ready = ~reset;
                if (swap_pending | (cfg_fire & cfg_last)) state_next = SWAP;
            end
            SWAP: begin
                state_next = RUN;
                filt_reset = reset | CLEAR_ON_SWAP;
                fill_clear = CLEAR_ON_SWAP;
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        fill_inc  = fill_sat_inc(fill_cnt);
        fill_next = fill_cnt;
        if (fill_clear)   fill_next = '0;
        else if (filt_en) fill_next = fill_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
            cfg_err      <= 1'b0;
            fill_cnt     <= '0;
            out_valid    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == SWAP) begin
                swap_pending <= 1'b0;
                active_bank  <= ~active_bank;
            end else if (cfg_fire & cfg_last) begin
                swap_pending <= 1'b1;
            end
            if (cfg_fire & ~addr_ok) cfg_err <= 1'b1;
            fill_cnt  <= fill_next;
            out_valid <= filt_en & (fill_inc >= CNT_W'(FILL_N));
        end
    end

endmodule
